fifo_wr_arb_ctrl: RTL and testbench

//  Front-end controller for one fifo_dut instance (pointer-compare FIFO, active-low wr_n/rd_n, 1-cycle read latency).
//  - Shares the FIFO write port among NUM_REQ valid/ready producers using round-robin arbitration.
//  - Tracks FIFO occupancy so over_flow/under_flow never occur, and drains the FIFO into one valid/ready stream.
//  - Provides a flush/drain sequence.

---
 rtl/fifo_wr_arb_ctrl.sv | 155 +++++++++++++++
 tb/tb_fifo_wr_arb_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb_ctrl.sv
// Round-robin write front-end and read-ahead drain controller for one fifo_dut; 4-clk write-to-output latency.
// Backpressure: req_ready drops when committed occupancy hits FIFO_DEPTH-1 or during drain; reads stall when the output buffer would overfill.
module fifo_wr_arb_ctrl #(
  parameter  int NUM_REQ    = 4,
  parameter  int FIFO_DEPTH = 16,
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  output logic                          flush_done,
  output logic                          fifo_wr_n,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_rd_n,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  input  logic                          fifo_over_flow,
  input  logic                          fifo_under_flow,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  output logic [CNT_W-1:0]              count,
  output logic                          err
);

  localparam int OBUF_DEPTH = 4;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_n_q, rd_n_q, rdret_vld_q, err_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] obuf_q [OBUF_DEPTH];
  logic [1:0]            obuf_head_q, obuf_tail_q;
  logic [2:0]            obuf_cnt_q, obuf_cnt_d;

  logic                  wr_allow, wr_xfer, rd_dec, run_st, drain_empty;
  logic                  obuf_push, obuf_pop;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic [1:0]            inflight;

  // Search from the RR pointer upward, wrapping; first valid requester wins.
  always_comb begin
    grant    = '0;
    win_idx  = '0;
    wr_xfer  = 1'b0;
    wr_allow = run_st && (count_q < CNT_MAX);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wr_allow && !wr_xfer && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant[(int'(rr_ptr_q) + k) % NUM_REQ] = 1'b1;
        win_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        wr_xfer = 1'b1;
      end
    end
  end

  assign win_data = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign rr_ptr_d = wr_xfer ? IDX_W'((int'(win_idx) + 1) % NUM_REQ) : rr_ptr_q;

  // Reads already issued or returning still need an output-buffer slot.
  assign inflight = {1'b0, ~rd_n_q} + {1'b0, rdret_vld_q};
  assign rd_dec   = (count_q != '0) && ((obuf_cnt_q + {1'b0, inflight}) < 3'(OBUF_DEPTH));

  always_comb begin
    count_d = count_q;
    if (wr_xfer && !rd_dec) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_dec && !wr_xfer) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign obuf_push  = rdret_vld_q;
  assign obuf_pop   = m_valid && m_ready;
  assign obuf_cnt_d = obuf_cnt_q + {2'b00, obuf_push} - {2'b00, obuf_pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      count_q     <= '0;
      wr_n_q      <= 1'b1;
      din_q       <= '0;
      rd_n_q      <= 1'b1;
      rdret_vld_q <= 1'b0;
      err_q       <= 1'b0;
      obuf_head_q <= '0;
      obuf_tail_q <= '0;
      obuf_cnt_q  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      wr_n_q      <= ~wr_xfer;
      rd_n_q      <= ~rd_dec;
      rdret_vld_q <= ~rd_n_q;
      err_q       <= err_q | fifo_over_flow | fifo_under_flow;
      obuf_cnt_q  <= obuf_cnt_d;
      if (wr_xfer) begin
        din_q <= win_data;
      end
      if (obuf_push) begin
        obuf_q[obuf_tail_q] <= fifo_dout;
        obuf_tail_q         <= obuf_tail_q + 2'd1;
      end
      if (obuf_pop) begin
        obuf_head_q <= obuf_head_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign drain_empty = (count_q == '0) && (inflight == 2'd0) && (obuf_cnt_q == 3'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_empty) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    run_st     = (state_q == ST_RUN);
    flush_done = (state_q == ST_DRAIN) && drain_empty;
  end

  assign req_ready = grant;
  assign fifo_wr_n = wr_n_q;
  assign fifo_din  = din_q;
  assign fifo_rd_n = rd_n_q;
  assign m_valid   = (obuf_cnt_q != 3'd0);
  assign m_data    = obuf_q[obuf_head_q];
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Randomized bench for fifo_wr_arb_ctrl with a queue-based fifo_dut stand-in and an in-order scoreboard.
module tb_fifo_wr_arb_ctrl;
  localparam int NR = 4;
  localparam int DEPTH = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, flush, flush_done, fifo_wr_n, fifo_rd_n;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    fifo_din, fifo_dout, m_data;
  logic             fifo_over_flow, fifo_under_flow, m_valid, m_ready, err;
  logic [3:0]       count;

  fifo_wr_arb_ctrl #(.NUM_REQ(NR), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .flush(flush), .flush_done(flush_done), .fifo_wr_n(fifo_wr_n), .fifo_din(fifo_din),
    .fifo_rd_n(fifo_rd_n), .fifo_dout(fifo_dout), .fifo_over_flow(fifo_over_flow),
    .fifo_under_flow(fifo_under_flow), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .count(count), .err(err)
  );

  // Behavioural fifo_dut: 1-cycle read latency, FIFO_DEPTH-1 usable entries.
  logic [DW-1:0] fq[$];
  logic          of_q, uf_q, uf_force;
  assign fifo_over_flow  = of_q;
  assign fifo_under_flow = uf_q | uf_force;

  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      fifo_dout <= '0;
      of_q      <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      of_q <= 1'b0;
      uf_q <= 1'b0;
      if (!fifo_rd_n) begin
        if (fq.size() == 0) uf_q <= 1'b1;
        else fifo_dout <= fq.pop_front();
      end
      if (!fifo_wr_n) begin
        if (fq.size() >= DEPTH - 1) of_q <= 1'b1;
        else fq.push_back(fifo_din);
      end
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] sbq[$];
  int            ptr, n_in, n_out;
  bit            drain_mode, prev_stall;
  logic [DW-1:0] prev_data;
  logic          s_mvalid, s_fd;
  logic [DW-1:0] s_mdata;
  logic [NR-1:0] s_rdy;
  logic [3:0]    s_count;

  function automatic logic [NR-1:0] exp_grant(input logic [NR-1:0] v, input int p);
    logic [NR-1:0] one = 1;
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return one << ((p + k) % NR);
    end
    return '0;
  endfunction

  task automatic tick();
    @(negedge clk);
    s_mvalid = m_valid;
    s_mdata  = m_data;
    s_rdy    = req_ready;
    s_count  = count;
    s_fd     = flush_done;
    if (rst_n) begin
      if (|req_valid) begin
        if (req_ready != '0) check("grant", int'(req_ready), int'(exp_grant(req_valid, ptr)));
        else if (!drain_mode) check("full_stall_count", int'(count), DEPTH - 1);
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sbq.push_back(req_data[i*DW +: DW]);
          ptr = (i + 1) % NR;
          n_in++;
        end
      end
      if (prev_stall) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_data", int'(m_data), int'(prev_data));
      end
      if (m_valid && m_ready) begin
        check("sb_nonempty", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) check("out_data", int'(m_data), int'(sbq.pop_front()));
        n_out++;
      end
      check("count_max", int'(count <= 4'(DEPTH - 1)), 1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    req_valid = '0;
    m_ready   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sbq.size() == 0 && !s_mvalid && s_count == 4'd0) break;
    end
    check("idle_sb_empty", sbq.size(), 0);
    check("idle_count", int'(s_count), 0);
    check("idle_mvalid", int'(s_mvalid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int sent, out0, nfd, npop;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; flush = 1'b0; m_ready = 1'b0; uf_force = 1'b0;
    ptr = 0; n_in = 0; n_out = 0; drain_mode = 1'b0; prev_stall = 1'b0; prev_data = '0;
    repeat (3) tick();
    check("rst_wr_n", int'(fifo_wr_n), 1);
    check("rst_rd_n", int'(fifo_rd_n), 1);
    check("rst_din", int'(fifo_din), 0);
    check("rst_mvalid", int'(m_valid), 0);
    check("rst_mdata", int'(m_data), 0);
    check("rst_count", int'(count), 0);
    check("rst_err", int'(err), 0);
    check("rst_flush_done", int'(flush_done), 0);
    rst_n = 1'b1;

    // Single-word latency on an empty system, then sustained rate
    m_ready = 1'b1;
    req_data[DW-1:0] = 8'hA5;
    req_valid = 4'b0001;
    tick();
    check("lat_handshake", int'(s_rdy), 1);
    req_valid = '0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      check($sformatf("lat_mvalid_t%0d", n), int'(s_mvalid), int'(n == 4));
    end
    check("lat_data", int'(s_mdata), 'hA5);
    wait_idle();

    npop = 0;
    req_valid = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      req_data[DW-1:0] = 8'(i + 'h40);
      tick();
      if (i >= 8 && s_mvalid) npop++;
    end
    check("rate_1_per_clk", npop, 32);
    wait_idle();

    // req0 burst with the output stalled, then overfill
    m_ready = 1'b0;
    req_valid = 4'b0001;
    sent = 0;
    out0 = n_out;
    for (int i = 0; i < 100 && sent < 16; i++) begin
      req_data[DW-1:0] = 8'('h11 + sent);
      tick();
      if (s_rdy[0]) sent++;
    end
    req_valid = '0;
    repeat (6) tick();
    check("burst_count", int'(s_count), 16 - 4);
    check("burst_mvalid", int'(s_mvalid), 1);
    check("burst_head", int'(s_mdata), 'h11);
    check("burst_err", int'(err), 0);
    req_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      req_data[DW-1:0] = 8'('h11 + sent);
      tick();
      if (s_rdy[0]) sent++;
    end
    check("fill_accepted", sent, 16 + 3);
    check("fill_count", int'(s_count), DEPTH - 1);
    check("fill_ready", int'(s_rdy), 0);
    wait_idle();
    check("burst_words_out", n_out - out0, 19);
    check("burst_err2", int'(err), 0);

    // All requesters active: round-robin order checked by the grant model and scoreboard
    req_valid = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < NR; r++) req_data[r*DW +: DW] = 8'((r << 6) | (i & 63));
      tick();
    end
    wait_idle();

    // Flush with 10 words queued
    m_ready = 1'b0;
    req_valid = 4'b0010;
    sent = 0;
    for (int i = 0; i < 100 && sent < 10; i++) begin
      req_data[DW +: DW] = 8'('h60 + sent);
      tick();
      if (s_rdy[1]) sent++;
    end
    req_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain_mode = 1'b1;
    m_ready = 1'b1;
    req_valid = 4'b0001;
    req_data[DW-1:0] = 8'h77;
    out0 = n_out;
    nfd = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("drain_ready", int'(s_rdy), 0);
      if (s_fd) begin
        nfd++;
        break;
      end
    end
    check("flush_done_seen", nfd, 1);
    check("drain_words", n_out - out0, 10);
    drain_mode = 1'b0;
    tick();
    check("ready_after_flush", int'(s_rdy), 1);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_done_single", int'(s_fd), 0);
    end
    wait_idle();

    // Random traffic: heavy stall phase then light stall phase
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      m_ready   = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end
    wait_idle();
    check("rand_in_eq_out", n_in, n_out);
    check("rand_err", int'(err), 0);

    // Alternating m_ready with traffic, then forced underflow
    for (int i = 0; i < 60; i++) begin
      req_valid = (i < 30) ? 4'($urandom_range(0, 15)) : 4'b0000;
      req_data  = $urandom;
      m_ready   = (i % 2 == 0);
      tick();
    end
    wait_idle();
    check("alt_err", int'(err), 0);
    uf_force = 1'b1;
    tick();
    uf_force = 1'b0;
    tick();
    check("err_set", int'(err), 1);
    repeat (5) tick();
    check("err_sticky", int'(err), 1);

    // Reset in the middle of traffic
    for (int i = 0; i < 20; i++) begin
      req_valid = 4'($urandom_range(1, 15));
      req_data  = $urandom;
      m_ready   = $urandom_range(0, 1) == 1;
      tick();
    end
    rst_n = 1'b0;
    req_valid = 4'b1111;
    sbq.delete();
    ptr = 0;
    repeat (2) tick();
    check("mid_rst_wr_n", int'(fifo_wr_n), 1);
    check("mid_rst_rd_n", int'(fifo_rd_n), 1);
    check("mid_rst_mvalid", int'(m_valid), 0);
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_err", int'(err), 0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    req_data = 32'h44332211;
    tick();
    check("mid_rst_ready", int'(s_rdy), 1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
